// File: rtl/rc4_pkg.sv
// RC4 shared definitions: S-memory geometry, KSA state encoding and the
// key-byte selector used by both ksa_fsm and decode_fsm.
package rc4_pkg;

  localparam int unsigned RC4_MEM_DEPTH     = 256;
  localparam int unsigned RC4_ADDR_W        = $clog2(RC4_MEM_DEPTH);
  localparam int unsigned RC4_MAX_KEY_BYTES = 32;
  localparam int unsigned RC4_KEY_MAX_W     = 8 * RC4_MAX_KEY_BYTES;

  // The j read is issued from CALC_J (address = next j), so no separate RD_J state exists.
  typedef enum logic [3:0] {
    KSA_IDLE    = 4'd0,
    KSA_INIT_WR = 4'd1,
    KSA_RD_I    = 4'd2,
    KSA_WAIT_I  = 4'd3,
    KSA_CALC_J  = 4'd4,
    KSA_WAIT_J  = 4'd5,
    KSA_WR_I    = 4'd6,
    KSA_WR_J    = 4'd7,
    KSA_DONE    = 4'd8
  } ksa_state_t;

  // Key byte (idx mod nbytes); byte 0 is the most significant byte of the key.
  // key is the zero-extended key, nbytes its real length in bytes.
  function automatic logic [7:0] key_byte(input logic [RC4_KEY_MAX_W-1:0] key,
                                          input int unsigned              nbytes,
                                          input logic [7:0]               idx);
    int unsigned              k;
    logic [RC4_KEY_MAX_W-1:0] sh;
    k  = 32'(idx) % nbytes;
    sh = key >> (8 * (nbytes - 1 - k));
    return sh[7:0];
  endfunction

endpackage

// File: rtl/ksa_fsm.sv
// RC4 key-scheduling stage: optionally fills S with the identity, then runs
// the 256-iteration KSA swap loop against a 2-cycle-latency sync RAM.
// Build option: define KSA_INIT_EN to include the S[i]=i initialisation phase;
// without it S must already hold the identity permutation.
module ksa_fsm
  import rc4_pkg::*;
#(
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned MEM_DEPTH = RC4_MEM_DEPTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [8*KEY_BYTES-1:0]  secret_key,
  input  logic [7:0]              data_in,
  output logic [RC4_ADDR_W-1:0]   address,
  output logic [7:0]              data_out,
  output logic                    write_enable,
  output logic                    done
);

  localparam logic [RC4_ADDR_W-1:0] LAST_IDX = RC4_ADDR_W'(MEM_DEPTH - 1);

  ksa_state_t                state, state_n;
  logic [RC4_ADDR_W-1:0]     i, i_n;
  logic [RC4_ADDR_W-1:0]     j, j_n;
  logic [7:0]                si, si_n;
  logic [8*KEY_BYTES-1:0]    key_reg, key_n;
  logic [7:0]                kb;
  logic                      i_last;

  assign i_last = (i == LAST_IDX);

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= KSA_IDLE;
      i       <= '0;
      j       <= '0;
      si      <= '0;
      key_reg <= '0;
    end else begin
      state   <= state_n;
      i       <= i_n;
      j       <= j_n;
      si      <= si_n;
      key_reg <= key_n;
    end
  end

  // Next-state, datapath updates and Moore memory-port decode.
  always_comb begin
    state_n      = state;
    i_n          = i;
    j_n          = j;
    si_n         = si;
    key_n        = key_reg;
    address      = '0;
    data_out     = '0;
    write_enable = 1'b0;
    done         = 1'b0;
    kb           = key_byte(RC4_KEY_MAX_W'(key_reg), KEY_BYTES, i);

    case (state)
      KSA_IDLE: begin
        if (start) begin
          key_n = secret_key;
          i_n   = '0;
          j_n   = '0;
`ifdef KSA_INIT_EN
          state_n = KSA_INIT_WR;
`else
          state_n = KSA_RD_I;
`endif
        end
      end

`ifdef KSA_INIT_EN
      KSA_INIT_WR: begin
        address      = i;
        data_out     = 8'(i);
        write_enable = 1'b1;
        i_n          = i + 1'b1;
        if (i_last) begin
          i_n     = '0;
          state_n = KSA_RD_I;
        end
      end
`endif

      KSA_RD_I: begin
        address = i;
        state_n = KSA_WAIT_I;
      end

      KSA_WAIT_I: begin
        state_n = KSA_CALC_J;
      end

      // S[i] arrives; the new j is both registered and issued as the next read.
      KSA_CALC_J: begin
        si_n    = data_in;
        j_n     = j + data_in + kb;
        address = j_n;
        state_n = KSA_WAIT_J;
      end

      KSA_WAIT_J: begin
        state_n = KSA_WR_I;
      end

      // S[j] is on data_in this cycle and is written straight back to S[i].
      KSA_WR_I: begin
        address      = i;
        data_out     = data_in;
        write_enable = 1'b1;
        state_n      = KSA_WR_J;
      end

      // Completes the swap; when i==j this second write leaves S[i] unchanged.
      KSA_WR_J: begin
        address      = j;
        data_out     = si;
        write_enable = 1'b1;
        if (i_last) begin
          state_n = KSA_DONE;
        end else begin
          i_n     = i + 1'b1;
          state_n = KSA_RD_I;
        end
      end

      // Held while start stays high so a level request cannot retrigger.
      KSA_DONE: begin
        done = 1'b1;
        if (!start) state_n = KSA_IDLE;
      end

      default: begin
        state_n = KSA_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ksa_fsm.sv
// Directed self-checking bench for ksa_fsm with a 256x8 sync RAM model
// (2-edge read latency) and an algorithmic RC4 KSA reference.
`timescale 1ns/1ps
module tb_ksa_fsm;

`ifdef KSA_INIT_EN
  localparam int INIT_N = 256;
  localparam logic [7:0] PRE_XOR = 8'hFF;
`else
  localparam int INIT_N = 0;
  localparam logic [7:0] PRE_XOR = 8'h00;
`endif
  localparam int LAT = INIT_N + 1536;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [23:0] secret_key = 24'h0;
  logic [7:0]  data_in;
  logic [7:0]  address;
  logic [7:0]  data_out;
  logic        write_enable;
  logic        done;

  always #5 clock = ~clock;

  ksa_fsm #(.KEY_BYTES(3), .MEM_DEPTH(256)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .secret_key   (secret_key),
    .data_in      (data_in),
    .address      (address),
    .data_out     (data_out),
    .write_enable (write_enable),
    .done         (done)
  );

  // RAM model with write log; preload and log clear are requested by the stimulus.
  logic [7:0] mem [256];
  logic [7:0] raddr_q = 8'h0;
  logic [7:0] q = 8'h0;
  logic       preload = 1'b0;
  logic       clr_log = 1'b0;
  logic [7:0] pre_xor = 8'h0;
  int         wcount = 0;
  logic [7:0] wl_addr [2048];
  logic [7:0] wl_data [2048];

  assign data_in = q;

  always @(posedge clock) begin
    if (preload) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k) ^ pre_xor;
    end else if (write_enable) begin
      mem[address] <= data_out;
      if (wcount < 2048) begin
        wl_addr[wcount] <= address;
        wl_data[wcount] <= data_out;
      end
      wcount <= wcount + 1;
    end
    if (clr_log) wcount <= 0;
    raddr_q <= address;
    q       <= mem[raddr_q];
  end

  logic [7:0] gold [256];
  int total  = 0;
  int passed = 0;
  int fails  = 0;

  task automatic gold_ksa(input logic [23:0] key);
    logic [7:0] kbytes [3];
    logic [7:0] jj;
    logic [7:0] t;
    kbytes[0] = key[23:16];
    kbytes[1] = key[15:8];
    kbytes[2] = key[7:0];
    for (int k = 0; k < 256; k++) gold[k] = 8'(k);
    jj = 8'h0;
    for (int k = 0; k < 256; k++) begin
      jj       = jj + gold[k] + kbytes[k % 3];
      t        = gold[k];
      gold[k]  = gold[jj];
      gold[jj] = t;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [7:0] ea, input logic [7:0] ed);
    chk(tag, 32'({wl_addr[idx], wl_data[idx]}), 32'({ea, ed}));
  endtask

  task automatic chk_mem(input string tag);
    int mism;
    mism = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== gold[k]) mism++;
    chk(tag, 32'(mism), 32'd0);
  endtask

  task automatic do_preload();
    @(negedge clock);
    preload = 1'b1;
    clr_log = 1'b1;
    pre_xor = PRE_XOR;
    @(negedge clock);
    preload = 1'b0;
    clr_log = 1'b0;
  endtask

  // Returns at the start-accept edge E0.
  task automatic start_run(input logic [23:0] key);
    @(negedge clock);
    secret_key = key;
    start      = 1'b1;
    @(posedge clock);
  endtask

  // Edge count (from E0) at which done is first seen high; bounded.
  task automatic wait_done(input int already, output int n);
    n = already;
    while (n < LAT + 64) begin
      @(posedge clock);
      #1;
      n++;
      if (done) break;
    end
  endtask

  int n;
  int wc_snap;

  initial begin
    // Reset state
    #2;
    chk("reset_outputs", 32'({address, data_out, write_enable, done}), 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Key 0: mid-run swap of S[2]/S[3], i==j no-op writes, full result
    do_preload();
    gold_ksa(24'h000000);
    start_run(24'h000000);
    repeat (INIT_N + 18) @(posedge clock);
    #1;
    chk("k0_s2_after_i2", 32'(mem[2]), 32'd3);
    chk("k0_s3_after_i2", 32'(mem[3]), 32'd2);
    wait_done(INIT_N + 18, n);
    chk("k0_latency", 32'(n), 32'(LAT));
    chk_mem("k0_s_dump");
    chk_wr("k0_wr_i0_first", INIT_N + 0, 8'd0, 8'd0);
    chk_wr("k0_wr_i0_second", INIT_N + 1, 8'd0, 8'd0);
    chk_wr("k0_wr_i1_first", INIT_N + 2, 8'd1, 8'd1);
    chk_wr("k0_wr_i1_second", INIT_N + 3, 8'd1, 8'd1);
    chk_wr("k0_wr_i2_first", INIT_N + 4, 8'd2, 8'd3);
    chk_wr("k0_wr_i2_second", INIT_N + 5, 8'd3, 8'd2);
    @(negedge clock);
    start = 1'b0;

    // Key 000249: exact latency, write count, j arithmetic, held-start behaviour
    do_preload();
    gold_ksa(24'h000249);
    start_run(24'h000249);
    wait_done(0, n);
    chk("k249_latency", 32'(n), 32'(LAT));
    chk("k249_write_count", 32'(wcount), 32'(INIT_N + 512));
    chk_mem("k249_s_dump");
    chk_wr("k249_wr_i1_first", INIT_N + 2, 8'd1, 8'd3);
    chk_wr("k249_wr_i1_second", INIT_N + 3, 8'd3, 8'd1);
    chk_wr("k249_wr_i2_first", INIT_N + 4, 8'd2, 8'h4E);
    chk_wr("k249_wr_i2_second", INIT_N + 5, 8'h4E, 8'd2);
    wc_snap = wcount;
    repeat (5) @(posedge clock);
    #1;
    chk("k249_done_held", 32'(done), 32'd1);
    chk("k249_no_restart", 32'(wcount), 32'(wc_snap));
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #1;
    chk("k249_done_falls", 32'(done), 32'd0);
    repeat (4) @(posedge clock);
    #1;
    chk("k249_idle_no_writes", 32'(wcount), 32'(wc_snap));

    // Reset at edge 900: immediate abort, then a clean restart
    do_preload();
    start_run(24'h000249);
    repeat (900) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_outputs", 32'({address, data_out, write_enable, done}), 32'd0);
    start = 1'b0;
    wc_snap = wcount;
    repeat (2) @(posedge clock);
    #1;
    chk("abort_no_writes", 32'(wcount), 32'(wc_snap));
    @(negedge clock);
    reset = 1'b1;
    do_preload();
    gold_ksa(24'h000249);
    start_run(24'h000249);
    wait_done(0, n);
    chk("restart_latency", 32'(n), 32'(LAT));
    chk_mem("restart_s_dump");
    @(negedge clock);
    start = 1'b0;

    // One-cycle start pulse, key changed at edge 10: original key used, done pulses once
    do_preload();
    gold_ksa(24'h5A13C7);
    start_run(24'h5A13C7);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    secret_key = 24'hFFFFFF;
    wait_done(9, n);
    chk("pulse_latency", 32'(n), 32'(LAT));
    @(posedge clock);
    #1;
    chk("pulse_done_one_cycle", 32'(done), 32'd0);
    chk_mem("pulse_s_dump");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
